// File: rtl/instr_mem_responder.sv
// Word-addressed instruction memory answering fetch requests after a fixed latency.
// A separate load port preloads program contents; out-of-range reads return OOR_DATA with an error flag.
module instr_mem_responder #(
    parameter int          BITSIZE  = 32,
    parameter int          DEPTH    = 256,
    parameter int          LATENCY  = 2,
    parameter logic [31:0] OOR_DATA = 32'h0000_0013
) (
    input  logic               clk,
    input  logic               reset_i,
    input  logic [BITSIZE-1:0] MEM_addr_i,
    input  logic               MEM_read_i,
    output logic [31:0]        MEM_data_o,
    output logic               MEM_valid_o,
    output logic               MEM_err_o,
    input  logic               load_en_i,
    input  logic [BITSIZE-1:0] load_addr_i,
    input  logic [31:0]        load_data_i
);

    // state     | meaning
    // S_IDLE    | waiting for a read request
    // S_WAIT    | request latched, counting down latency
    // S_RESPOND | valid pulse cycle; no new request accepted here

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESPOND} state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [BITSIZE-1:0] addr_q, addr_d;
    logic [31:0]        data_q, data_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;

    logic [31:0]        mem [DEPTH];
    logic [BITSIZE-1:0] rd_addr;
    logic               rd_oor;
    logic [31:0]        rd_word;
    logic               load_ok;

    // In IDLE the capture can only happen with LATENCY=1, using the live address.
    always_comb begin
        rd_addr = (state_q == S_IDLE) ? MEM_addr_i : addr_q;
        rd_oor  = (rd_addr >= BITSIZE'(DEPTH));
        rd_word = rd_oor ? OOR_DATA : mem[rd_addr[AW-1:0]];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (MEM_read_i) begin
                    addr_d = MEM_addr_i;
                    cnt_d  = 4'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        data_d  = rd_word;
                        err_d   = rd_oor;
                        valid_d = 1'b1;
                        state_d = S_RESPOND;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!MEM_read_i) begin
                    cnt_d   = 4'd0;
                    state_d = S_IDLE;
                end else if (cnt_q <= 4'd1) begin
                    data_d  = rd_word;
                    err_d   = rd_oor;
                    valid_d = 1'b1;
                    cnt_d   = 4'd0;
                    state_d = S_RESPOND;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESPOND: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            data_q  <= 32'd0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    // Array is never cleared; a same-edge load and capture yields the old word.
    assign load_ok = !reset_i && load_en_i && (load_addr_i < BITSIZE'(DEPTH));

    always_ff @(posedge clk) begin
        if (load_ok) begin
            mem[load_addr_i[AW-1:0]] <= load_data_i;
        end
    end

    assign MEM_data_o  = data_q;
    assign MEM_valid_o = valid_q;
    assign MEM_err_o   = err_q;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Directed bench for instr_mem_responder: a LATENCY=2 instance for most checks and
// a LATENCY=4 instance for the abort case, both sharing clock, reset and load port.
module tb_instr_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr, addr4;
    logic        read, read4;
    logic [31:0] data, data4;
    logic        valid, valid4;
    logic        err, err4;
    logic        load_en;
    logic [31:0] load_addr;
    logic [31:0] load_data;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int last_v = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    instr_mem_responder #(.BITSIZE(32), .DEPTH(256), .LATENCY(2), .OOR_DATA(32'h0000_0013)) dut (
        .clk(clk), .reset_i(reset),
        .MEM_addr_i(addr), .MEM_read_i(read),
        .MEM_data_o(data), .MEM_valid_o(valid), .MEM_err_o(err),
        .load_en_i(load_en), .load_addr_i(load_addr), .load_data_i(load_data)
    );

    instr_mem_responder #(.BITSIZE(32), .DEPTH(256), .LATENCY(4), .OOR_DATA(32'h0000_0013)) dut4 (
        .clk(clk), .reset_i(reset),
        .MEM_addr_i(addr4), .MEM_read_i(read4),
        .MEM_data_o(data4), .MEM_valid_o(valid4), .MEM_err_o(err4),
        .load_en_i(load_en), .load_addr_i(load_addr), .load_data_i(load_data)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        bit          e;
        int          sp;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic load_word(input logic [31:0] a, input logic [31:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        @(posedge clk); #1;
        load_en   = 1'b0;
    endtask

    // Raise read, scramble the address after acceptance, wait for valid, drop read.
    task automatic do_read(input bit w4, input logic [31:0] a, input logic [31:0] exp_d,
                           input bit exp_e, input int exp_lat, input bit ld,
                           input logic [31:0] ld_d, input int space, input string nm);
        int k;
        bit got;
        if (w4) begin read4 = 1'b1; addr4 = a; end
        else    begin read  = 1'b1; addr  = a; end
        got = 1'b0;
        k   = 0;
        while (!got && k < 20) begin
            @(posedge clk); #1;
            k++;
            load_en = 1'b0;
            if (w4 ? valid4 : valid) begin
                got = 1'b1;
            end else if (k == 1) begin
                if (w4) addr4 = a ^ 32'd1;
                else    addr  = a ^ 32'd1;
                if (ld) begin
                    load_en   = 1'b1;
                    load_addr = a;
                    load_data = ld_d;
                end
            end
        end
        read  = 1'b0;
        read4 = 1'b0;
        chk({nm, " valid_seen"}, 32'(got), 32'd1);
        if (got) begin
            chk({nm, " latency"}, 32'(k), 32'(exp_lat));
            chk({nm, " data"}, w4 ? data4 : data, exp_d);
            chk({nm, " err"}, 32'(w4 ? err4 : err), 32'(exp_e));
            if (space > 0) chk({nm, " spacing"}, 32'(cyc - last_v), 32'(space));
            if (!w4) last_v = cyc;
        end
        @(posedge clk); #1;
        chk({nm, " valid_one_cycle"}, 32'(w4 ? valid4 : valid), 32'd0);
        chk({nm, " err_after"}, 32'(w4 ? err4 : err), 32'd0);
    endtask

    initial begin
        int pulses;

        tbl[0] = '{a: 32'd0,   d: 32'h0010_0093, e: 1'b0, sp: 0};
        tbl[1] = '{a: 32'd1,   d: 32'h0020_0113, e: 1'b0, sp: 3};
        tbl[2] = '{a: 32'd2,   d: 32'h0030_8193, e: 1'b0, sp: 3};
        tbl[3] = '{a: 32'd3,   d: 32'h0041_8213, e: 1'b0, sp: 3};
        tbl[4] = '{a: 32'd300, d: 32'h0000_0013, e: 1'b1, sp: 3};

        reset = 1'b1; read = 1'b0; read4 = 1'b0; addr = '0; addr4 = '0;
        load_en = 1'b0; load_addr = '0; load_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset valid", 32'(valid), 32'd0);
        chk("reset data", data, 32'd0);
        chk("reset err", 32'(err), 32'd0);
        reset = 1'b0;

        load_word(32'd0,  32'h0010_0093);
        load_word(32'd1,  32'h0020_0113);
        load_word(32'd2,  32'h0030_8193);
        load_word(32'd3,  32'h0041_8213);
        load_word(32'd44, 32'h1111_1111);

        for (int i = 0; i < 5; i++) begin
            do_read(1'b0, tbl[i].a, tbl[i].d, tbl[i].e, 2, 1'b0, 32'd0, tbl[i].sp,
                    $sformatf("vec%0d", i));
        end

        // Out-of-range load must not alias onto addr 44.
        load_word(32'd300, 32'hCAFE_BABE);
        do_read(1'b0, 32'd44, 32'h1111_1111, 1'b0, 2, 1'b0, 32'd0, 0, "oor_load_alias");

        // Abort in WAIT on the LATENCY=4 instance.
        read4 = 1'b1; addr4 = 32'd0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        read4 = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (valid4) pulses++;
        end
        chk("abort no_pulse", 32'(pulses), 32'd0);
        do_read(1'b1, 32'd2, 32'h0030_8193, 1'b0, 4, 1'b0, 32'd0, 0, "after_abort");

        // Reset during WAIT drops the request.
        read = 1'b1; addr = 32'd3;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_wait valid", 32'(valid), 32'd0);
        chk("rst_wait data", data, 32'd0);
        chk("rst_wait err", 32'(err), 32'd0);
        reset = 1'b0;
        read  = 1'b0;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (valid) pulses++;
        end
        chk("rst_wait no_pulse", 32'(pulses), 32'd0);
        do_read(1'b0, 32'd3, 32'h0041_8213, 1'b0, 2, 1'b0, 32'd0, 0, "after_reset");

        // Load colliding with the capture edge returns the old word.
        do_read(1'b0, 32'd1, 32'h0020_0113, 1'b0, 2, 1'b1, 32'hDEAD_BEEF, 0, "rbw_old");
        do_read(1'b0, 32'd1, 32'hDEAD_BEEF, 1'b0, 2, 1'b0, 32'd0, 0, "rbw_new");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
